// File: rtl/lift_pkg.sv
// Shared lift controller types and default timing/load constants.
// No logic, no latency.
// No flow control.
package lift_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_MOVE,
        ST_DOOR_OPEN,
        ST_DOOR_CLOSE
    } lift_state_e;

    localparam int DEF_NUM_FLOORS    = 8;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 8;
    localparam int DEF_CLOSE_CYCLES  = 2;
    localparam int DEF_WEIGHT_W      = 10;
    localparam int DEF_MAX_WEIGHT    = 700;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lift_req_queue.sv
// Pending-call register with direction flags relative to the current floor.
// Calls visible on pending one clock after they are presented; flags are combinational from the register.
// No backpressure: calls are level inputs, merged every powered clock.
module lift_req_queue
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  powered,
    input  logic [NUM_FLOORS-1:0] calls,
    input  logic                  mask_vld,
    input  logic [FLOOR_W-1:0]    mask_floor,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] clr_mask;

    // The floor the door is (or is about to be) open at is both cleared and
    // blocked, so a press there restarts the door instead of queueing a stop.
    always_comb begin
        clr_mask = '0;
        if (mask_vld) clr_mask[mask_floor] = 1'b1;
    end

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) any_above = 1'b1;
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) any_below = 1'b1;
        end
    end

    assign here = pending[cur_floor];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         pending <= '0;
        else if (!powered) pending <= '0;
        else               pending <= (pending | calls) & ~clr_mask;
    end

endmodule

// File: rtl/lift_ctrl_multi.sv
// Single-car collective SCAN lift controller with timed door, overload hold and power-loss handling.
// All outputs registered; a new call is acted on two clocks after it is presented.
// No backpressure: calls latch into the pending set; door buttons and load are sampled every clock.
module lift_ctrl_multi
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
    parameter int CLOSE_CYCLES  = DEF_CLOSE_CYCLES,
    parameter int WEIGHT_W      = DEF_WEIGHT_W,
    parameter int MAX_WEIGHT    = DEF_MAX_WEIGHT
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_power,
    input  logic                  i_battery,
    input  logic [WEIGHT_W-1:0]   i_weight,
    input  logic [NUM_FLOORS-1:0] i_call_up,
    input  logic [NUM_FLOORS-1:0] i_call_down,
    input  logic [NUM_FLOORS-1:0] i_car_call,
    input  logic                  i_open,
    input  logic                  i_close,
    output logic [FLOOR_W-1:0]    o_floor,
    output logic                  o_moving,
    output logic                  o_dir_up,
    output logic                  o_open,
    output logic                  o_close,
    output logic                  o_overload,
    output logic [NUM_FLOORS-1:0] o_pending
);

    localparam int CNT_W = $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, CLOSE_CYCLES) + 1);
    localparam logic [CNT_W-1:0]    TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CLOSE_LAST  = CNT_W'(CLOSE_CYCLES - 1);
    localparam logic [WEIGHT_W-1:0] WEIGHT_LIM  = WEIGHT_W'(MAX_WEIGHT);

    lift_state_e            state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic [FLOOR_W-1:0]     floor_n;
    logic                   dir_n;
    logic                   powered, overload, call_here, door_n;
    logic                   any_above, any_below, here;
    logic [NUM_FLOORS-1:0]  calls;

    assign powered   = i_power && i_battery;
    assign overload  = i_weight > WEIGHT_LIM;
    assign calls     = i_call_up | i_call_down | i_car_call;
    assign call_here = powered && calls[o_floor];
    assign door_n    = (state_n == ST_DOOR_OPEN) || (state_n == ST_DOOR_CLOSE);

    lift_req_queue #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_queue (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .powered    (powered),
        .calls      (calls),
        .mask_vld   (door_n),
        .mask_floor (floor_n),
        .cur_floor  (o_floor),
        .pending    (o_pending),
        .any_above  (any_above),
        .any_below  (any_below),
        .here       (here)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        floor_n = o_floor;
        dir_n   = o_dir_up;
        unique case (state_q)
            ST_OFF: begin
                cnt_n = '0;
                if (powered) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_n = '0;
                if (!powered) begin
                    state_n = ST_OFF;
                end else if (here) begin
                    state_n = ST_DOOR_OPEN;
                end else if (o_dir_up ? any_above : any_below) begin
                    state_n = ST_MOVE;
                end else if (any_above || any_below) begin
                    dir_n   = !o_dir_up;
                    state_n = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_n   = '0;
                    floor_n = o_dir_up ? o_floor + FLOOR_W'(1) : o_floor - FLOOR_W'(1);
                    // Continue only while work remains beyond the new floor, so the car never runs off either end.
                    if (!powered || o_pending[floor_n])
                        state_n = ST_DOOR_OPEN;
                    else if (!(o_dir_up ? any_above : any_below))
                        state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (powered) begin
                    if (overload || i_open || call_here) begin
                        cnt_n = '0;
                    end else if (i_close || (cnt_q == DOOR_LAST)) begin
                        cnt_n   = '0;
                        state_n = ST_DOOR_CLOSE;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DOOR_CLOSE: begin
                if (!powered || i_open || overload || call_here) begin
                    cnt_n   = '0;
                    state_n = ST_DOOR_OPEN;
                end else if (cnt_q == CLOSE_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            o_floor    <= '0;
            o_dir_up   <= 1'b1;
            o_moving   <= 1'b0;
            o_open     <= 1'b0;
            o_close    <= 1'b1;
            o_overload <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            o_floor    <= floor_n;
            o_dir_up   <= dir_n;
            o_moving   <= (state_n == ST_MOVE);
            o_open     <= (state_n == ST_DOOR_OPEN);
            o_close    <= !door_n;
            o_overload <= door_n && overload;
        end
    end

endmodule

// File: tb/tb_lift_ctrl_multi.sv
// Scenario bench for lift_ctrl_multi: each door opening is scoreboarded against the expected stop floor,
// scenario tasks check timing and state inline.
module tb_lift_ctrl_multi;

    logic       i_clk = 1'b0;
    logic       i_rst, i_power, i_battery, i_open, i_close;
    logic [9:0] i_weight;
    logic [7:0] i_call_up, i_call_down, i_car_call;
    logic [2:0] o_floor;
    logic       o_moving, o_dir_up, o_open, o_close, o_overload;
    logic [7:0] o_pending;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic prev_open = 1'b0;

    always #5 i_clk = ~i_clk;

    lift_ctrl_multi #(
        .NUM_FLOORS    (8),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (8),
        .CLOSE_CYCLES  (2),
        .WEIGHT_W      (10),
        .MAX_WEIGHT    (700)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_power     (i_power),
        .i_battery   (i_battery),
        .i_weight    (i_weight),
        .i_call_up   (i_call_up),
        .i_call_down (i_call_down),
        .i_car_call  (i_car_call),
        .i_open      (i_open),
        .i_close     (i_close),
        .o_floor     (o_floor),
        .o_moving    (o_moving),
        .o_dir_up    (o_dir_up),
        .o_open      (o_open),
        .o_close     (o_close),
        .o_overload  (o_overload),
        .o_pending   (o_pending)
    );

    // Every rising o_open must match the next expected stop floor.
    always @(posedge i_clk) begin : mon
        int e;
        #2;
        if (o_open === 1'b1 && prev_open !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stop_unexpected door opened at floor=%0d with no stop expected", o_floor);
            end else begin
                e = exp_q.pop_front();
                if (int'(o_floor) !== e) begin
                    failures++;
                    $display("FAIL stop_floor got=%0d want=%0d", o_floor, e);
                end
            end
        end
        prev_open = o_open;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(o_close === 1'b1 && o_moving === 1'b0 && o_pending === 8'h00) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL wait_idle timeout floor=%0d moving=%0b close=%0b pending=%h", o_floor, o_moving, o_close, o_pending);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_power = 1'b0; i_battery = 1'b0; i_weight = '0;
        i_call_up = '0; i_call_down = '0; i_car_call = '0; i_open = 1'b0; i_close = 1'b0;
        repeat (2) tick();
        checks++; if (o_floor !== 3'd0)   begin failures++; $display("FAIL reset_floor got=%0d want=0", o_floor); end
        checks++; if (o_moving !== 1'b0)  begin failures++; $display("FAIL reset_moving got=%0b want=0", o_moving); end
        checks++; if (o_dir_up !== 1'b1)  begin failures++; $display("FAIL reset_dir got=%0b want=1", o_dir_up); end
        checks++; if (o_open !== 1'b0)    begin failures++; $display("FAIL reset_open got=%0b want=0", o_open); end
        checks++; if (o_close !== 1'b1)   begin failures++; $display("FAIL reset_close got=%0b want=1", o_close); end
        checks++; if (o_overload !== 1'b0) begin failures++; $display("FAIL reset_overload got=%0b want=0", o_overload); end
        checks++; if (o_pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h want=00", o_pending); end
        i_rst = 1'b0;
        tick();
        checks++; if (o_close !== 1'b1 || o_moving !== 1'b0) begin failures++; $display("FAIL off_state close=%0b moving=%0b want 1/0", o_close, o_moving); end
    endtask

    task automatic test_travel();
        i_power = 1'b1; i_battery = 1'b1;
        repeat (3) tick();
        i_car_call = 8'h20; exp_q.push_back(5);
        tick();
        i_car_call = '0;
        checks++; if (o_pending !== 8'h20) begin failures++; $display("FAIL travel_pending got=%h want=20", o_pending); end
        checks++; if (o_moving !== 1'b0)   begin failures++; $display("FAIL travel_early_move got=%0b want=0", o_moving); end
        tick();
        checks++; if (o_moving !== 1'b1 || o_dir_up !== 1'b1) begin failures++; $display("FAIL travel_start moving=%0b dir=%0b want 1/1", o_moving, o_dir_up); end
        for (int f = 1; f <= 5; f++) begin
            repeat (4) tick();
            checks++; if (o_floor !== 3'(f)) begin failures++; $display("FAIL travel_floor got=%0d want=%0d", o_floor, f); end
        end
        checks++; if (o_open !== 1'b1 || o_moving !== 1'b0) begin failures++; $display("FAIL travel_arrive open=%0b moving=%0b want 1/0", o_open, o_moving); end
        checks++; if (o_pending !== 8'h00) begin failures++; $display("FAIL travel_clear got=%h want=00", o_pending); end
        repeat (7) tick();
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL door_hold got=%0b want=1", o_open); end
        tick();
        checks++; if (o_open !== 1'b0 || o_close !== 1'b0) begin failures++; $display("FAIL door_closing open=%0b close=%0b want 0/0", o_open, o_close); end
        tick();
        checks++; if (o_close !== 1'b0) begin failures++; $display("FAIL door_closing2 got=%0b want=0", o_close); end
        tick();
        checks++; if (o_close !== 1'b1) begin failures++; $display("FAIL door_closed got=%0b want=1", o_close); end
    endtask

    task automatic test_scan();
        i_car_call = 8'h04; exp_q.push_back(2); tick(); i_car_call = '0;
        wait_idle(200);
        checks++; if (o_floor !== 3'd2 || o_dir_up !== 1'b0) begin failures++; $display("FAIL scan_at2 floor=%0d dir=%0b want 2/0", o_floor, o_dir_up); end
        i_car_call = 8'h08; exp_q.push_back(3); tick(); i_car_call = '0;
        wait_idle(200);
        checks++; if (o_floor !== 3'd3 || o_dir_up !== 1'b1) begin failures++; $display("FAIL scan_at3 floor=%0d dir=%0b want 3/1", o_floor, o_dir_up); end
        i_car_call = 8'h40; i_call_down = 8'h02;
        exp_q.push_back(6); exp_q.push_back(1);
        tick();
        i_car_call = '0; i_call_down = '0;
        checks++; if (o_pending !== 8'h42) begin failures++; $display("FAIL scan_pending got=%h want=42", o_pending); end
        tick();
        checks++; if (o_moving !== 1'b1 || o_dir_up !== 1'b1) begin failures++; $display("FAIL scan_dir moving=%0b dir=%0b want 1/1", o_moving, o_dir_up); end
        wait_idle(300);
        checks++; if (o_floor !== 3'd1 || o_dir_up !== 1'b0) begin failures++; $display("FAIL scan_end floor=%0d dir=%0b want 1/0", o_floor, o_dir_up); end
    endtask

    task automatic test_overload();
        i_car_call = 8'h02; exp_q.push_back(1); tick(); i_car_call = '0;
        tick();
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL ovl_open got=%0b want=1", o_open); end
        i_weight = 10'd750;
        tick();
        checks++; if (o_overload !== 1'b1) begin failures++; $display("FAIL ovl_flag got=%0b want=1", o_overload); end
        repeat (12) tick();
        checks++; if (o_open !== 1'b1 || o_overload !== 1'b1) begin failures++; $display("FAIL ovl_hold open=%0b ovl=%0b want 1/1", o_open, o_overload); end
        i_weight = 10'd600;
        repeat (7) tick();
        checks++; if (o_open !== 1'b1 || o_overload !== 1'b0) begin failures++; $display("FAIL ovl_release open=%0b ovl=%0b want 1/0", o_open, o_overload); end
        tick();
        checks++; if (o_open !== 1'b0) begin failures++; $display("FAIL ovl_close got=%0b want=0", o_open); end
        wait_idle(50);
    endtask

    task automatic test_door_buttons();
        i_car_call = 8'h02; exp_q.push_back(1); tick(); i_car_call = '0;
        tick();
        repeat (8) tick();
        checks++; if (o_open !== 1'b0 || o_close !== 1'b0) begin failures++; $display("FAIL btn_closing open=%0b close=%0b want 0/0", o_open, o_close); end
        i_open = 1'b1; exp_q.push_back(1);
        tick();
        i_open = 1'b0;
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL btn_reopen got=%0b want=1", o_open); end
        repeat (7) tick();
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL btn_restart got=%0b want=1", o_open); end
        tick();
        checks++; if (o_open !== 1'b0) begin failures++; $display("FAIL btn_timeout got=%0b want=0", o_open); end
        wait_idle(50);
        i_car_call = 8'h02; exp_q.push_back(1); tick(); i_car_call = '0;
        tick();
        i_open = 1'b1; i_close = 1'b1;
        tick();
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL btn_both got=%0b want=1", o_open); end
        i_open = 1'b0;
        tick();
        i_close = 1'b0;
        checks++; if (o_open !== 1'b0 || o_close !== 1'b0) begin failures++; $display("FAIL btn_close open=%0b close=%0b want 0/0", o_open, o_close); end
        tick();
        checks++; if (o_close !== 1'b0) begin failures++; $display("FAIL btn_close2 got=%0b want=0", o_close); end
        tick();
        checks++; if (o_close !== 1'b1) begin failures++; $display("FAIL btn_closed got=%0b want=1", o_close); end
    endtask

    task automatic test_power_loss();
        i_car_call = 8'h01; exp_q.push_back(0); tick(); i_car_call = '0;
        wait_idle(100);
        checks++; if (o_floor !== 3'd0) begin failures++; $display("FAIL pwr_at0 got=%0d want=0", o_floor); end
        i_car_call = 8'h80; exp_q.push_back(3); tick(); i_car_call = '0;
        tick();
        checks++; if (o_moving !== 1'b1 || o_dir_up !== 1'b1) begin failures++; $display("FAIL pwr_start moving=%0b dir=%0b want 1/1", o_moving, o_dir_up); end
        repeat (9) tick();
        checks++; if (o_floor !== 3'd2) begin failures++; $display("FAIL pwr_seg got=%0d want=2", o_floor); end
        i_power = 1'b0;
        tick();
        checks++; if (o_pending !== 8'h00 || o_moving !== 1'b1) begin failures++; $display("FAIL pwr_drop pending=%h moving=%0b want 00/1", o_pending, o_moving); end
        repeat (2) tick();
        checks++; if (o_floor !== 3'd3 || o_open !== 1'b1 || o_moving !== 1'b0) begin failures++; $display("FAIL pwr_stop floor=%0d open=%0b moving=%0b want 3/1/0", o_floor, o_open, o_moving); end
        i_car_call = 8'h20;
        repeat (15) tick();
        i_car_call = '0;
        checks++; if (o_open !== 1'b1 || o_pending !== 8'h00) begin failures++; $display("FAIL pwr_hold open=%0b pending=%h want 1/00", o_open, o_pending); end
        i_power = 1'b1;
        repeat (7) tick();
        checks++; if (o_open !== 1'b1) begin failures++; $display("FAIL pwr_resume got=%0b want=1", o_open); end
        tick();
        checks++; if (o_open !== 1'b0) begin failures++; $display("FAIL pwr_close got=%0b want=0", o_open); end
        wait_idle(50);
        checks++; if (o_floor !== 3'd3) begin failures++; $display("FAIL pwr_idle_floor got=%0d want=3", o_floor); end
    endtask

    task automatic test_reset_mid();
        i_car_call = 8'h40; tick(); i_car_call = '0;
        tick();
        repeat (5) tick();
        checks++; if (o_moving !== 1'b1) begin failures++; $display("FAIL rstmid_moving got=%0b want=1", o_moving); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_floor !== 3'd0)   begin failures++; $display("FAIL rstmid_floor got=%0d want=0", o_floor); end
        checks++; if (o_moving !== 1'b0)  begin failures++; $display("FAIL rstmid_moving0 got=%0b want=0", o_moving); end
        checks++; if (o_dir_up !== 1'b1)  begin failures++; $display("FAIL rstmid_dir got=%0b want=1", o_dir_up); end
        checks++; if (o_close !== 1'b1 || o_open !== 1'b0) begin failures++; $display("FAIL rstmid_door close=%0b open=%0b want 1/0", o_close, o_open); end
        checks++; if (o_pending !== 8'h00) begin failures++; $display("FAIL rstmid_pending got=%h want=00", o_pending); end
        tick();
        i_rst = 1'b0;
        repeat (2) tick();
        i_car_call = 8'h04; exp_q.push_back(2); tick(); i_car_call = '0;
        wait_idle(200);
        checks++; if (o_floor !== 3'd2) begin failures++; $display("FAIL rstmid_after got=%0d want=2", o_floor); end
    endtask

    initial begin
        test_reset();
        test_travel();
        test_scan();
        test_overload();
        test_door_buttons();
        test_power_loss();
        test_reset_mid();
        repeat (3) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stops_missing remaining=%0d want=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
